// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide issue stage.
//   mdu_op_t    : operation encoding carried from execute
//   mdu_state_t : issue-stage FSM states
//   mdu_req_t   : one latched request (op, flags, operands, destination tag)
//   sext32      : sign-extend a 32-bit value to XLEN
package mdu_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;

  typedef enum logic [1:0] {
    MDU_MUL = 2'd0,
    MDU_DIV = 2'd1,
    MDU_REM = 2'd2
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_ISSUE,
    MDU_WAIT,
    MDU_HOLD
  } mdu_state_t;

  typedef struct packed {
    mdu_op_t          op;
    logic             word;
    logic             unsign;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] rd;
  } mdu_req_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_issue_fastpath.sv
// Combinational corner-case decode for the multiply/divide issue stage.
// Resolves divide-by-zero, signed overflow and multiply-by-zero without the
// iterative unit. Word ops compare only the low 32 bits and their results are
// sign-extended from bit 31.
// Ports:
//   op_i, word_i, unsign_i : operation and flags
//   a_i, b_i               : operands
//   hit_o                  : operation resolved here
//   result_o               : result, valid when hit_o
module mdu_fastpath
  import mdu_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic            unsign_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            hit_o,
  output logic [XLEN-1:0] result_o
);

  logic            a_zero, b_zero, b_neg1, a_min, ovf;
  logic [XLEN-1:0] raw;

  always_comb begin
    a_zero = word_i ? (a_i[31:0] == 32'd0) : (a_i == '0);
    b_zero = word_i ? (b_i[31:0] == 32'd0) : (b_i == '0);
    b_neg1 = word_i ? (b_i[31:0] == 32'hFFFF_FFFF) : (b_i == '1);
    a_min  = word_i ? (a_i[31:0] == 32'h8000_0000) : (a_i == {1'b1, {(XLEN-1){1'b0}}});
    // Signed MIN / -1 overflows; the quotient wraps back to MIN, remainder is 0.
    ovf    = !unsign_i && a_min && b_neg1;
    hit_o  = 1'b0;
    raw    = '0;
    case (mdu_op_t'(op_i))
      MDU_MUL: begin
        if (a_zero || b_zero) hit_o = 1'b1;
      end
      MDU_DIV: begin
        if (b_zero) begin
          hit_o = 1'b1;
          raw   = '1;
        end else if (ovf) begin
          hit_o = 1'b1;
          raw   = a_i;
        end
      end
      MDU_REM: begin
        if (b_zero) begin
          hit_o = 1'b1;
          raw   = a_i;
        end else if (ovf) begin
          hit_o = 1'b1;
        end
      end
      default: ;
    endcase
    result_o = word_i ? sext32(raw[31:0]) : raw;
  end

endmodule

// File: rtl/mdu_issue.sv
// Issue/collect stage in front of the iterative multiply/divide unit.
// Accepts one op in IDLE, launches the unit, waits for completion, then holds
// the result until the memory stage takes it. busy_o stalls execute throughout.
// Optional build macro: MDU_FASTPATH_EN resolves corner cases in IDLE
// (one-cycle latency) via mdu_fastpath; without it every op uses the unit.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   in_*                    : request from execute (valid/ready handshake)
//   flush_i                 : abandon current op
//   unit_start_o/unit_kill_o: launch / abort pulses to the iterative unit
//   unit_op/word/unsign/a/b : latched request fields for the unit
//   unit_done_i/result_i    : completion from the unit
//   out_*                   : result to memory stage (valid/ready handshake)
//   busy_o                  : stage occupied
module mdu_issue
  import mdu_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic             in_word_i,
  input  logic             in_unsign_i,
  input  logic [XLEN-1:0]  in_a_i,
  input  logic [XLEN-1:0]  in_b_i,
  input  logic [TAG_W-1:0] in_rd_i,
  input  logic             flush_i,
  output logic             unit_start_o,
  output logic             unit_kill_o,
  output logic [1:0]       unit_op_o,
  output logic             unit_word_o,
  output logic             unit_unsign_o,
  output logic [XLEN-1:0]  unit_a_o,
  output logic [XLEN-1:0]  unit_b_o,
  input  logic             unit_done_i,
  input  logic [XLEN-1:0]  unit_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_result_o,
  output logic [TAG_W-1:0] out_rd_o,
  output logic             busy_o
);

  mdu_state_t      state_q;
  mdu_req_t        req_q, in_req;
  logic [XLEN-1:0] result_q;
  logic            in_ready_q, busy_q, out_valid_q, unit_start_q;
  logic            fp_hit;
  logic [XLEN-1:0] fp_result;

  always_comb begin
    in_req.op     = mdu_op_t'(in_op_i);
    in_req.word   = in_word_i;
    in_req.unsign = in_unsign_i;
    in_req.a      = in_a_i;
    in_req.b      = in_b_i;
    in_req.rd     = in_rd_i;
  end

`ifdef MDU_FASTPATH_EN
  mdu_fastpath u_fastpath (
    .op_i     (in_op_i),
    .word_i   (in_word_i),
    .unsign_i (in_unsign_i),
    .a_i      (in_a_i),
    .b_i      (in_b_i),
    .hit_o    (fp_hit),
    .result_o (fp_result)
  );
`else
  assign fp_hit    = 1'b0;
  assign fp_result = '0;
`endif

  // Flush wins over every other event, so it is handled before the state decode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= MDU_IDLE;
      req_q        <= '0;
      result_q     <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      unit_start_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= MDU_IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      unit_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (in_valid_i) begin
            req_q      <= in_req;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (fp_hit) begin
              result_q    <= fp_result;
              out_valid_q <= 1'b1;
              state_q     <= MDU_HOLD;
            end else begin
              unit_start_q <= 1'b1;
              state_q      <= MDU_ISSUE;
            end
          end
        end
        MDU_ISSUE: begin
          unit_start_q <= 1'b0;
          state_q      <= MDU_WAIT;
        end
        MDU_WAIT: begin
          if (unit_done_i) begin
            result_q    <= unit_result_i;
            out_valid_q <= 1'b1;
            state_q     <= MDU_HOLD;
          end
        end
        MDU_HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  // Never present start and kill together; the unit resets itself on reset.
  assign unit_start_o  = unit_start_q & ~flush_i & ~reset_i;
  assign unit_kill_o   = flush_i & ~reset_i & ((state_q == MDU_ISSUE) || (state_q == MDU_WAIT));
  assign in_ready_o    = in_ready_q;
  assign busy_o        = busy_q;
  assign out_valid_o   = out_valid_q;
  assign out_result_o  = result_q;
  assign out_rd_o      = req_q.rd;
  assign unit_op_o     = req_q.op;
  assign unit_word_o   = req_q.word;
  assign unit_unsign_o = req_q.unsign;
  assign unit_a_o      = req_q.a;
  assign unit_b_o      = req_q.b;

endmodule

// File: tb/tb_mdu_issue.sv
// Directed self-checking bench for mdu_issue; adapts the corner-case vectors
// to whether MDU_FASTPATH_EN is defined.
module tb_mdu_issue;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_word, in_unsign, flush;
  logic [1:0]  in_op, unit_op;
  logic [63:0] in_a, in_b, unit_a, unit_b, unit_result, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        unit_start, unit_kill, unit_word, unit_unsign, unit_done;
  logic        out_valid, out_ready, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_issue dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_op_i       (in_op),
    .in_word_i     (in_word),
    .in_unsign_i   (in_unsign),
    .in_a_i        (in_a),
    .in_b_i        (in_b),
    .in_rd_i       (in_rd),
    .flush_i       (flush),
    .unit_start_o  (unit_start),
    .unit_kill_o   (unit_kill),
    .unit_op_o     (unit_op),
    .unit_word_o   (unit_word),
    .unit_unsign_o (unit_unsign),
    .unit_a_o      (unit_a),
    .unit_b_o      (unit_b),
    .unit_done_i   (unit_done),
    .unit_result_i (unit_result),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_result_o  (out_result),
    .out_rd_o      (out_rd),
    .busy_o        (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one op in IDLE; returns just after the accepting edge.
  task automatic issue(input mdu_op_t op, input logic w, input logic u,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_word = w; in_unsign = u; in_a = a; in_b = b; in_rd = rd;
    #1;
    check("in_ready_at_accept", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
  endtask

  // Model the unit: done on the n-th WAIT cycle. Ends in HOLD (or on budget).
  task automatic run_unit(input int n, input logic [63:0] res,
                          output int lat, output int starts, output int busy_cyc);
    lat = 0; starts = 0; busy_cyc = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (out_valid) break;
      unit_done   = (k == n);
      unit_result = res;
      #1;
      starts   += int'(unit_start);
      busy_cyc += int'(busy);
      if (k == 3) check("unit_a_stable", unit_a, in_a);
      cycle();
      unit_done = 1'b0;
      lat = k + 2;
    end
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("in_ready_after_take", 64'(in_ready), 64'd1);
  endtask

  task automatic corner(input string tag, input mdu_op_t op, input logic w, input logic u,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int lat, starts, bc;
    issue(op, w, u, a, b, 5'd3);
`ifdef MDU_FASTPATH_EN
    check({tag, "_valid_next"}, 64'(out_valid), 64'd1);
    check({tag, "_no_start"}, 64'(unit_start), 64'd0);
    check({tag, "_result"}, out_result, exp);
`else
    // Without the fast path the unit owns the corner case; feed it the answer.
    run_unit(2, exp, lat, starts, bc);
    check({tag, "_one_start"}, 64'(starts), 64'd1);
    check({tag, "_result"}, out_result, exp);
`endif
    release_hold();
  endtask

  int lat, starts, busy_cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_word = 1'b0; in_unsign = 1'b0;
    in_a = '0; in_b = '0; in_rd = '0; flush = 1'b0; unit_done = 1'b0; unit_result = '0;
    out_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_unit_start", 64'(unit_start), 64'd0);
    check("rst_out_result", out_result, 64'd0);

    // 1: slow-path MUL, unit takes 16 cycles.
    cycle();
    issue(MDU_MUL, 1'b0, 1'b0, 64'd6, 64'd7, 5'd9);
    run_unit(16, 64'd42, lat, starts, busy_cyc);
    check("mul_out_valid", 64'(out_valid), 64'd1);
    check("mul_latency", 64'(lat), 64'd18);
    check("mul_one_start", 64'(starts), 64'd1);
    check("mul_result", out_result, 64'd42);
    check("mul_rd", 64'(out_rd), 64'd9);
    busy_cyc += int'(busy);
    release_hold();
    check("mul_busy_cycles", 64'(busy_cyc), 64'd18);
    check("mul_idle_busy", 64'(busy), 64'd0);

    // 2/3: corner cases.
    corner("div0", MDU_DIV, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    corner("divw_ovf", MDU_DIV, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF,
           64'hFFFF_FFFF_8000_0000);
    corner("remw_ovf", MDU_REM, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
    corner("rem0", MDU_REM, 1'b0, 1'b1, 64'h1234, 64'd0, 64'h1234);
    corner("remw0", MDU_REM, 1'b1, 1'b0, 64'h1_8000_0005, 64'h7_0000_0000,
           64'hFFFF_FFFF_8000_0005);
    corner("mul0", MDU_MUL, 1'b0, 1'b0, 64'd0, 64'd99, 64'd0);
    corner("div_ovf", MDU_DIV, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000);

    // 4: flush in WAIT with a coincident unit_done.
    issue(MDU_DIV, 1'b0, 1'b0, 64'd100, 64'd7, 5'd4);
    cycle();
    flush = 1'b1; unit_done = 1'b1; unit_result = 64'd123;
    #1;
    check("flush_kill", 64'(unit_kill), 64'd1);
    cycle();
    flush = 1'b0; unit_done = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_no_valid", 64'(out_valid), 64'd0);
    cycle();
    check("flush_no_valid_later", 64'(out_valid), 64'd0);
    // in_valid together with flush in IDLE is dropped.
    in_valid = 1'b1; flush = 1'b1;
    cycle();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 64'(busy), 64'd0);
    // Stray unit_done in IDLE is ignored.
    unit_done = 1'b1;
    cycle();
    unit_done = 1'b0;
    check("idle_done_ignored", 64'(out_valid), 64'd0);

    // 5: backpressure in HOLD.
    issue(MDU_MUL, 1'b0, 1'b1, 64'd3, 64'd5, 5'd17);
    run_unit(4, 64'd15, lat, starts, busy_cyc);
    for (int i = 0; i < 5; i++) begin
      check("hold_result", out_result, 64'd15);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_valid", 64'(out_valid), 64'd1);
      cycle();
    end
    release_hold();
    check("hold_released_busy", 64'(busy), 64'd0);

    // 6: reset during ISSUE, then a normal op.
    issue(MDU_DIV, 1'b0, 1'b0, 64'd50, 64'd3, 5'd21);
    check("issue_start", 64'(unit_start), 64'd1);
    reset = 1'b1;
    #1;
    check("reset_no_kill", 64'(unit_kill), 64'd0);
    cycle();
    reset = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_start", 64'(unit_start), 64'd0);
    check("mid_rst_unit_a", unit_a, 64'd0);
    check("mid_rst_rd", 64'(out_rd), 64'd0);
    issue(MDU_MUL, 1'b0, 1'b0, 64'd7, 64'd11, 5'd30);
    run_unit(5, 64'd77, lat, starts, busy_cyc);
    check("post_rst_latency", 64'(lat), 64'd7);
    check("post_rst_result", out_result, 64'd77);
    check("post_rst_rd", 64'(out_rd), 64'd30);
    release_hold();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
